depth_test_writeback: RTL and testbench

- Downstream neighbour of the depth fetch stage.
- Consumes fetched pixels as {address, colour, old depth, new depth, done}.
- Performs the depth test. For passing pixels it writes colour to the pixel word at addr and the new depth to addr+4 over the Avalon-MM master.
- Buffers in-flight fetch results in an internal FIFO and back-pressures the fetch stage through stall_out.

---
 rtl/depth_test_writeback_if.sv | 33 +++
 rtl/depth_test_writeback.sv | 180 ++++++++++++++++++
 tb/tb_depth_test_writeback.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/depth_test_writeback_if.sv
// Avalon-MM master bus used by the depth-test writeback stage.
//   address     26-bit byte address
//   write       write request, held until accepted
//   read        read request (the writeback stage never reads)
//   byteenable  byte lanes, always all four
//   writedata   32-bit write data
//   waitrequest slave stall; a write is accepted when write & !waitrequest
interface depth_test_writeback_if;
    logic [25:0] address;
    logic        write;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address,
        output write,
        output read,
        output byteenable,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  read,
        input  byteenable,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/depth_test_writeback.sv
// Depth test and writeback stage, downstream of the depth fetch stage.
// Fetched pixels are queued in a FIFO; each popped pixel is depth tested and,
// if it passes, its colour is written to addr and its new depth to addr+4.
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   input_valid          one-cycle pulse, fetch result present (no back-pressure)
//   addr_in .. done_in   fetched pixel fields
//   stall_out            asks the fetch stage to stop issuing reads
//   master               Avalon-MM master bus
//   frame_done           one-cycle pulse when a done-tagged pixel retires
//   pixels_written       passing pixels whose two writes were accepted
//   pixels_killed        pixels that failed the depth test
//   overflow_error       sticky; a pixel arrived while the FIFO was full
module depth_test_writeback #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SKID       = 4,
    parameter int unsigned LESS_EQUAL = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          input_valid,
    input  logic [25:0]                   addr_in,
    input  logic [23:0]                   color_in,
    input  logic [31:0]                   old_depth_in,
    input  logic [31:0]                   new_depth_in,
    input  logic                          done_in,
    output logic                          stall_out,
    depth_test_writeback_if.master        master,
    output logic                          frame_done,
    output logic [31:0]                   pixels_written,
    output logic [31:0]                   pixels_killed,
    output logic                          overflow_error
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - SKID);

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
        logic [31:0] old_depth;
        logic [31:0] new_depth;
        logic        done;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WR_COLOR, S_WR_DEPTH} state_t;

    entry_t          mem [FIFO_DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            pop;
    logic            push;
    logic            head_pass;
    logic            accept;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [25:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     depth_q, depth_d;
    logic            done_q, done_d;
    logic            frame_done_q, frame_done_d;
    logic [31:0]     written_q, written_d;
    logic [31:0]     killed_q, killed_d;
    logic            overflow_q;

    assign in_entry = '{addr: addr_in, color: color_in, old_depth: old_depth_in,
                        new_depth: new_depth_in, done: done_in};
    assign head     = mem[rd_ptr_q];
    assign full     = (count_q == FULL_COUNT);
    // A pop on the same edge frees a slot, so a push into a full FIFO is legal then.
    assign push     = input_valid && (!full || pop);
    assign accept   = write_q && !master.waitrequest;

    always_comb begin
        if (LESS_EQUAL != 0) head_pass = (head.new_depth <= head.old_depth);
        else                 head_pass = (head.new_depth <  head.old_depth);
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        depth_d      = depth_q;
        done_d       = done_q;
        frame_done_d = 1'b0;
        written_d    = written_q;
        killed_d     = killed_q;
        pop          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_pass) begin
                        state_d = S_WR_COLOR;
                        write_d = 1'b1;
                        addr_d  = head.addr;
                        data_d  = {8'h00, head.color};
                        depth_d = head.new_depth;
                        done_d  = head.done;
                    end else begin
                        killed_d     = killed_q + 32'd1;
                        frame_done_d = head.done;
                    end
                end
            end
            S_WR_COLOR: begin
                if (accept) begin
                    addr_d  = addr_q + 26'd4;
                    data_d  = depth_q;
                    state_d = S_WR_DEPTH;
                end
            end
            S_WR_DEPTH: begin
                if (accept) begin
                    write_d      = 1'b0;
                    written_d    = written_q + 32'd1;
                    frame_done_d = done_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            depth_q      <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            written_q    <= '0;
            killed_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            depth_q      <= depth_d;
            done_q       <= done_d;
            frame_done_q <= frame_done_d;
            written_q    <= written_d;
            killed_q     <= killed_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_q + CW'(push) - CW'(pop);
            overflow_q <= overflow_q | (input_valid & full & ~pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= in_entry;
    end

    assign stall_out         = (count_q >= STALL_LEVEL);
    assign master.address    = addr_q;
    assign master.write      = write_q;
    assign master.writedata  = data_q;
    assign master.read       = 1'b0;
    assign master.byteenable = 4'b1111;
    assign frame_done        = frame_done_q;
    assign pixels_written    = written_q;
    assign pixels_killed     = killed_q;
    assign overflow_error    = overflow_q;

endmodule

// File: tb/tb_depth_test_writeback.sv
// Bench for depth_test_writeback: dut0 uses strict less-than, dut1 less-or-equal.
// A queue-level model of each DUT is stepped on every rising edge and compared
// against the DUT outputs each cycle; directed literal checks pin the model.
module tb_depth_test_writeback;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SKIDN  = 4;
    localparam time         PERIOD = 10;

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
        logic [31:0] old_depth;
        logic [31:0] new_depth;
        logic        done;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [25:0] in_addr = '0;
    logic [23:0] in_color = '0;
    logic [31:0] in_old = '0;
    logic [31:0] in_new = '0;
    logic        in_done = 1'b0;
    logic        waitreq = 1'b0;
    logic        cmp_en = 1'b0;

    logic [1:0]  act_stall, act_fd, act_ovf, act_write;
    logic [31:0] act_written [2];
    logic [31:0] act_killed [2];
    logic [25:0] act_addr [2];
    logic [31:0] act_data [2];

    depth_test_writeback_if bus0 ();
    depth_test_writeback_if bus1 ();
    assign bus0.waitrequest = waitreq;
    assign bus1.waitrequest = waitreq;

    always #(PERIOD / 2) clock = ~clock;

    depth_test_writeback #(.FIFO_DEPTH(DEPTH), .SKID(SKIDN), .LESS_EQUAL(0)) dut0 (
        .clock(clock), .reset(reset), .input_valid(in_valid), .addr_in(in_addr),
        .color_in(in_color), .old_depth_in(in_old), .new_depth_in(in_new),
        .done_in(in_done), .stall_out(act_stall[0]), .master(bus0),
        .frame_done(act_fd[0]), .pixels_written(act_written[0]),
        .pixels_killed(act_killed[0]), .overflow_error(act_ovf[0])
    );

    depth_test_writeback #(.FIFO_DEPTH(DEPTH), .SKID(SKIDN), .LESS_EQUAL(1)) dut1 (
        .clock(clock), .reset(reset), .input_valid(in_valid), .addr_in(in_addr),
        .color_in(in_color), .old_depth_in(in_old), .new_depth_in(in_new),
        .done_in(in_done), .stall_out(act_stall[1]), .master(bus1),
        .frame_done(act_fd[1]), .pixels_written(act_written[1]),
        .pixels_killed(act_killed[1]), .overflow_error(act_ovf[1])
    );

    assign act_write   = {bus1.write, bus0.write};
    assign act_addr[0] = bus0.address;
    assign act_addr[1] = bus1.address;
    assign act_data[0] = bus0.writedata;
    assign act_data[1] = bus1.writedata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each pixel is a queue entry; the one being written is "current", walking
    // through colour-write then depth-write pending phases.
    entry_t      mq [2][$];
    entry_t      m_cur [2];
    int          m_phase [2];
    logic        m_write [2];
    logic [25:0] m_addr [2];
    logic [31:0] m_data [2];
    logic        m_fd [2];
    logic [31:0] m_written [2];
    logic [31:0] m_killed [2];
    logic        m_ovf [2];

    task automatic model_clear(input int d);
        mq[d].delete();
        m_phase[d] = 0; m_write[d] = 1'b0; m_addr[d] = '0; m_data[d] = '0;
        m_fd[d] = 1'b0; m_written[d] = '0; m_killed[d] = '0; m_ovf[d] = 1'b0;
        m_cur[d] = '0;
    endtask

    task automatic model_step(input int d);
        entry_t e;
        bit     acc;
        bit     pass;
        acc = m_write[d] && !waitreq;
        m_fd[d] = 1'b0;
        if (m_phase[d] == 0) begin
            if (mq[d].size() != 0) begin
                e = mq[d].pop_front();
                pass = (d == 1) ? (e.new_depth <= e.old_depth) : (e.new_depth < e.old_depth);
                if (pass) begin
                    m_cur[d] = e; m_phase[d] = 1; m_write[d] = 1'b1;
                    m_addr[d] = e.addr; m_data[d] = {8'h00, e.color};
                end else begin
                    m_killed[d] = m_killed[d] + 32'd1;
                    m_fd[d] = e.done;
                end
            end
        end else if (m_phase[d] == 1) begin
            if (acc) begin
                m_phase[d] = 2;
                m_addr[d] = m_cur[d].addr + 26'd4;
                m_data[d] = m_cur[d].new_depth;
            end
        end else if (acc) begin
            m_phase[d] = 0; m_write[d] = 1'b0;
            m_written[d] = m_written[d] + 32'd1;
            m_fd[d] = m_cur[d].done;
        end
        if (in_valid) begin
            if (mq[d].size() < DEPTH)
                mq[d].push_back('{addr: in_addr, color: in_color, old_depth: in_old,
                                  new_depth: in_new, done: in_done});
            else
                m_ovf[d] = 1'b1;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_clear(0);
            model_clear(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- compare + bus monitor ----------------
    logic [57:0] log0 [$];
    int          fd_cnt = 0;
    time         fd_time = 0;
    time         acc_time = 0;

    always begin
        @(negedge clock);
        #2;
        if (!reset && cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("write", d, 64'(act_write[d]), 64'(m_write[d]));
                if (m_write[d]) begin
                    chk("address", d, 64'(act_addr[d]), 64'(m_addr[d]));
                    chk("writedata", d, 64'(act_data[d]), 64'(m_data[d]));
                end
                chk("frame_done", d, 64'(act_fd[d]), 64'(m_fd[d]));
                chk("pixels_written", d, 64'(act_written[d]), 64'(m_written[d]));
                chk("pixels_killed", d, 64'(act_killed[d]), 64'(m_killed[d]));
                chk("stall_out", d, 64'(act_stall[d]), 64'(mq[d].size() >= DEPTH - SKIDN));
                chk("overflow_error", d, 64'(act_ovf[d]), 64'(m_ovf[d]));
            end
            if (bus0.write && !waitreq) begin
                log0.push_back({bus0.address, bus0.writedata});
                acc_time = $time;
            end
            if (act_fd[0]) begin
                fd_cnt++;
                fd_time = $time;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [25:0] a, input logic [23:0] c, input logic [31:0] od,
                        input logic [31:0] nd, input logic dn);
        in_valid = 1'b1; in_addr = a; in_color = c; in_old = od; in_new = nd; in_done = dn;
        @(negedge clock);
        in_valid = 1'b0; in_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        log0.delete();
        fd_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(mq[0].size() == 0 && mq[1].size() == 0 && m_phase[0] == 0 &&
                 m_phase[1] == 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", 0, 64'(n < 300), 64'd1);
        @(negedge clock);
    endtask

    time t0;

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_write", 0, 64'(bus0.write), 64'd0);
        chk("rst_address", 0, 64'(bus0.address), 64'd0);
        chk("rst_writedata", 0, 64'(bus0.writedata), 64'd0);
        chk("rst_counters", 0, {act_written[0], act_killed[0]}, 64'd0);
        chk("rst_flags", 0, 64'({act_ovf[0], act_fd[0], act_stall[0]}), 64'd0);
        chk("read_tied", 0, 64'(bus0.read), 64'd0);
        chk("byteenable_tied", 0, 64'(bus0.byteenable), 64'hF);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cmp_en = 1'b1;

        // 1: single passing pixel
        push(26'h100, 24'hABCDEF, 32'h5000, 32'h1000, 1'b0);
        drain();
        chk("t1_nwrites", 0, 64'(log0.size()), 64'd2);
        chk("t1_color_write", 0, 64'(log0[0]), {6'd0, 26'h100, 32'h00ABCDEF});
        chk("t1_depth_write", 0, 64'(log0[1]), {6'd0, 26'h104, 32'h00001000});
        chk("t1_written", 0, 64'(act_written[0]), 64'd1);
        chk("t1_killed", 0, 64'(act_killed[0]), 64'd0);

        // 2: greater and equal depths
        do_reset();
        push(26'h200, 24'h111111, 32'h5000, 32'h6000, 1'b0);
        push(26'h300, 24'h222222, 32'h5000, 32'h5000, 1'b0);
        drain();
        chk("t2_nwrites", 0, 64'(log0.size()), 64'd0);
        chk("t2_killed", 0, 64'(act_killed[0]), 64'd2);
        chk("t2_le_written", 1, 64'(act_written[1]), 64'd1);
        chk("t2_le_killed", 1, 64'(act_killed[1]), 64'd1);

        // 3: waitrequest 3 cycles on colour, 2 on depth
        do_reset();
        waitreq = 1'b1;
        push(26'h3FFFFFC, 24'h123456, 32'hFFFF, 32'h10, 1'b0);
        @(negedge clock);
        repeat (3) begin
            @(negedge clock);
            chk("t3_hold_addr", 0, 64'(bus0.address), 64'h3FFFFFC);
        end
        waitreq = 1'b0;
        @(negedge clock);
        waitreq = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("t3_hold_data", 0, 64'(bus0.writedata), 64'h10);
        end
        waitreq = 1'b0;
        drain();
        chk("t3_nwrites", 0, 64'(log0.size()), 64'd2);
        chk("t3_depth_wrap", 0, 64'(log0[1]), {6'd0, 26'h0000000, 32'h10});
        chk("t3_written", 0, 64'(act_written[0]), 64'd1);

        // 4: fill and overflow with the bus stuck
        do_reset();
        waitreq = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(26'(i * 16), 24'(i), 32'h100, 32'(i), 1'b0);
            if (i == 3) chk("t4_stall_low", 0, 64'(act_stall[0]), 64'd0);
            if (i == 4) chk("t4_stall_high", 0, 64'(act_stall[0]), 64'd1);
        end
        chk("t4_no_ovf_9", 0, 64'(act_ovf[0]), 64'd0);
        push(26'h900, 24'h999999, 32'h100, 32'h1, 1'b0);
        chk("t4_ovf_10", 0, 64'(act_ovf[0]), 64'd1);
        repeat (3) @(negedge clock);
        waitreq = 1'b0;
        drain();
        chk("t4_ovf_sticky", 0, 64'(act_ovf[0]), 64'd1);
        chk("t4_written", 0, 64'(act_written[0]), 64'd9);

        // 5: frame_done on third passing pixel, then on a killed pixel
        do_reset();
        push(26'h500, 24'hA, 32'h100, 32'h1, 1'b0);
        push(26'h510, 24'hB, 32'h100, 32'h2, 1'b0);
        push(26'h520, 24'hC, 32'h100, 32'h3, 1'b1);
        drain();
        chk("t5_fd_count", 0, 64'(fd_cnt), 64'd1);
        chk("t5_fd_after_accept", 0, 64'(fd_time), 64'(acc_time + PERIOD));
        chk("t5_last_write", 0, 64'(log0[5]), {6'd0, 26'h524, 32'h3});
        fd_cnt = 0;
        push(26'h600, 24'hD, 32'h100, 32'h9000, 1'b1);
        t0 = $time;
        drain();
        chk("t5_kill_fd_count", 0, 64'(fd_cnt), 64'd1);
        chk("t5_kill_fd_time", 0, 64'(fd_time), 64'(t0 + PERIOD + 2));

        // 6: reset while the depth write is pending with 3 queued
        waitreq = 1'b1;
        for (int i = 0; i < 4; i++) push(26'(32'h700 + i * 16), 24'h5, 32'h80, 32'h8, 1'b0);
        waitreq = 1'b0;
        @(negedge clock);
        waitreq = 1'b1;
        @(negedge clock);
        chk("t6_pre_write", 0, 64'(bus0.write), 64'd1);
        chk("t6_pre_addr", 0, 64'(bus0.address), 64'h704);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_write", 0, 64'(act_write), 64'd0);
        chk("t6_counters", 0, {act_written[0], act_killed[0]}, 64'd0);
        chk("t6_stall", 0, 64'(act_stall), 64'd0);
        @(negedge clock);
        @(negedge clock);
        log0.delete();
        reset = 1'b0;
        waitreq = 1'b0;
        repeat (20) @(negedge clock);
        chk("t6_no_writes", 0, 64'(log0.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
